// File: rtl/pito_irq_dispatcher.sv
// MVU -> pito interrupt dispatcher: routes irq_evt_t events into per-hart FIFOs
// and presents pending level, head data, occupancy and overflow status per hart.

module pito_irq_queue #(
  parameter int Q_DEPTH = 4,
  parameter int DATA_W  = 32,
  parameter int PW      = 2,
  parameter int CW      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic              ack,
  input  logic              ovf_clr,
  output logic              pend,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     cnt,
  output logic              ovf,
  output logic              drop
);
  logic [DATA_W-1:0] mem [Q_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              pop, full, accept;

  assign pop    = ack && (count != '0);
  assign full   = (count == CW'(Q_DEPTH));
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data;
  end

  assign pend = (count != '0);
  assign head = pend ? mem[rd_ptr] : '0;
  assign cnt  = count;
endmodule

module pito_irq_dispatcher #(
  parameter int NUM_HARTS  = 8,
  parameter int Q_DEPTH    = 4,
  parameter int DATA_W     = 32,
  parameter int DROP_CNT_W = 16,
  localparam int HID_W = $clog2(NUM_HARTS) + 1,
  localparam int PW    = $clog2(Q_DEPTH),
  localparam int CW    = PW + 1,
  localparam int EVT_W = HID_W + DATA_W + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [EVT_W-1:0]            irq_evt_i,
  input  logic [NUM_HARTS-1:0]        irq_ack_i,
  input  logic [NUM_HARTS-1:0]        ovf_clr_i,
  output logic [NUM_HARTS-1:0]        mvip_o,
  output logic [NUM_HARTS*DATA_W-1:0] irq_data_o,
  output logic [NUM_HARTS*CW-1:0]     irq_cnt_o,
  output logic [NUM_HARTS-1:0]        ovf_o,
  output logic [DROP_CNT_W-1:0]       drop_cnt_o
);
  typedef struct packed {
    logic [HID_W-1:0]  hart_id;
    logic [DATA_W-1:0] data;
    logic              valid;
  } irq_evt_t;

  irq_evt_t             evt;
  logic                 tgt_ok, drop_any;
  logic [NUM_HARTS-1:0] push, lane_drop;

  assign evt    = irq_evt_t'(irq_evt_i);
  assign tgt_ok = evt.valid && (evt.hart_id < HID_W'(NUM_HARTS));

  genvar h;
  generate
    for (h = 0; h < NUM_HARTS; h++) begin : g_hart
      assign push[h] = tgt_ok && (evt.hart_id == HID_W'(h));
      pito_irq_queue #(.Q_DEPTH(Q_DEPTH), .DATA_W(DATA_W), .PW(PW), .CW(CW)) u_q (
        .clk    (clk),
        .rst    (rst),
        .push   (push[h]),
        .data   (evt.data),
        .ack    (irq_ack_i[h]),
        .ovf_clr(ovf_clr_i[h]),
        .pend   (mvip_o[h]),
        .head   (irq_data_o[h*DATA_W +: DATA_W]),
        .cnt    (irq_cnt_o[h*CW +: CW]),
        .ovf    (ovf_o[h]),
        .drop   (lane_drop[h])
      );
    end
  endgenerate

  // Single input channel: at most one drop per cycle, from a bad target or a full queue.
  assign drop_any = (evt.valid && !tgt_ok) || (|lane_drop);

  always_ff @(posedge clk) begin
    if (rst)                                   drop_cnt_o <= '0;
    else if (drop_any && (drop_cnt_o != '1))   drop_cnt_o <= drop_cnt_o + 1'b1;
  end
endmodule
